// File: rtl/ps2_key_encoder.sv
// PS/2 (scan set 2) receiver: conditions the raw lines, deserializes 11-bit frames,
// tracks E0/F0 prefixes and emits 5-bit calculator key codes with a one-cycle strobe.
module ps2_key_encoder #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 100000,
    parameter int TIMEOUT_W  = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [4:0] data,
    output logic       cifra_noua,
    output logic       frame_err
);

    localparam int         FW      = $clog2(FILTER_LEN + 1);
    localparam logic [4:0] KEY_REL = 5'd30;
    localparam logic [4:0] NO_KEY  = 5'd31;

    typedef enum logic       {IDLE, RECV} frame_e;
    typedef enum logic [1:0] {NORMAL, EXT, BRK, EXT_BRK} pfx_e;

    logic [1:0]           clk_s_q, clk_s_d, dat_s_q, dat_s_d;
    logic                 filt_q, filt_d;
    logic [FW-1:0]        fcnt_q, fcnt_d;
    frame_e               frame_q, frame_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [8:0]           shift_q, shift_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    pfx_e                 pfx_q, pfx_d;
    logic [4:0]           last_q, last_d, data_q, data_d;
    logic                 cn_q, cn_d, err_q, err_d;

    logic       fall, sbit, byte_vld, bad, do_make, do_rel;
    logic [7:0] rx_byte;
    logic [5:0] map_r;

    // Returns {hit, code}; hit=0 for unmapped scan codes.
    function automatic logic [5:0] map_code(input logic [7:0] b, input logic ext);
        logic [5:0] r;
        r = '0;
        if (ext) begin
            case (b)
                8'h4A:   r = {1'b1, 5'd14};
                8'h5A:   r = {1'b1, 5'd10};
                default: r = '0;
            endcase
        end else begin
            case (b)
                8'h45, 8'h70: r = {1'b1, 5'd0};
                8'h16, 8'h69: r = {1'b1, 5'd1};
                8'h1E, 8'h72: r = {1'b1, 5'd2};
                8'h26, 8'h7A: r = {1'b1, 5'd3};
                8'h25, 8'h6B: r = {1'b1, 5'd4};
                8'h2E, 8'h73: r = {1'b1, 5'd5};
                8'h36, 8'h74: r = {1'b1, 5'd6};
                8'h3D, 8'h6C: r = {1'b1, 5'd7};
                8'h3E, 8'h75: r = {1'b1, 5'd8};
                8'h46, 8'h7D: r = {1'b1, 5'd9};
                8'h5A:        r = {1'b1, 5'd10};
                8'h79:        r = {1'b1, 5'd11};
                8'h7B:        r = {1'b1, 5'd12};
                8'h7C:        r = {1'b1, 5'd13};
                8'h4A:        r = {1'b1, 5'd14};
                8'h2B:        r = {1'b1, 5'd15};
                8'h4D:        r = {1'b1, 5'd16};
                8'h2D:        r = {1'b1, 5'd17};
                8'h76:        r = {1'b1, 5'd18};
                default:      r = '0;
            endcase
        end
        return r;
    endfunction

    always_comb begin
        clk_s_d   = {clk_s_q[0], ps2_clk};
        dat_s_d   = {dat_s_q[0], ps2_data};
        filt_d    = filt_q;
        fcnt_d    = fcnt_q;
        frame_d   = frame_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tmo_d     = tmo_q;
        pfx_d     = pfx_q;
        last_d    = last_q;
        data_d    = data_q;
        cn_d      = 1'b0;
        err_d     = 1'b0;
        byte_vld  = 1'b0;
        bad       = 1'b0;
        do_make   = 1'b0;
        do_rel    = 1'b0;
        rx_byte   = shift_q[7:0];
        sbit      = dat_s_q[1];

        // Level flips only after FILTER_LEN consecutive samples disagree with it.
        if (clk_s_q[1] == filt_q) begin
            fcnt_d = '0;
        end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
            filt_d = clk_s_q[1];
            fcnt_d = '0;
        end else begin
            fcnt_d = fcnt_q + 1'b1;
        end
        fall = filt_q & ~filt_d;

        case (frame_q)
            IDLE: begin
                tmo_d = '0;
                if (fall && !sbit) begin
                    frame_d   = RECV;
                    bit_cnt_d = 4'd1;
                end
            end
            default: begin
                if (fall) begin
                    tmo_d = '0;
                    if (bit_cnt_q == 4'd10) begin
                        frame_d   = IDLE;
                        bit_cnt_d = '0;
                        if ((^shift_q) && sbit) byte_vld = 1'b1;
                        else                    bad      = 1'b1;
                    end else begin
                        shift_d   = {sbit, shift_q[8:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (tmo_q == TIMEOUT_W'(TIMEOUT)) begin
                    frame_d   = IDLE;
                    bit_cnt_d = '0;
                    bad       = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
        endcase

        if (bad) begin
            err_d = 1'b1;
            pfx_d = NORMAL;
        end

        map_r = map_code(rx_byte, (pfx_q == EXT) || (pfx_q == EXT_BRK));
        if (byte_vld) begin
            case (pfx_q)
                NORMAL: begin
                    if (rx_byte == 8'hE0)      pfx_d = EXT;
                    else if (rx_byte == 8'hF0) pfx_d = BRK;
                    else                       do_make = 1'b1;
                end
                EXT: begin
                    if (rx_byte == 8'hF0) begin
                        pfx_d = EXT_BRK;
                    end else begin
                        do_make = 1'b1;
                        pfx_d   = NORMAL;
                    end
                end
                default: begin
                    do_rel = 1'b1;
                    pfx_d  = NORMAL;
                end
            endcase
        end

        // A repeated make of the held key is typematic and stays silent.
        if (do_make && map_r[5] && (map_r[4:0] != last_q)) begin
            data_d = map_r[4:0];
            cn_d   = 1'b1;
            last_d = map_r[4:0];
        end
        if (do_rel && map_r[5]) begin
            data_d = KEY_REL;
            cn_d   = 1'b1;
            last_d = NO_KEY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s_q   <= 2'b11;
            dat_s_q   <= 2'b11;
            filt_q    <= 1'b1;
            fcnt_q    <= '0;
            frame_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tmo_q     <= '0;
            pfx_q     <= NORMAL;
            last_q    <= NO_KEY;
            data_q    <= '0;
            cn_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            clk_s_q   <= clk_s_d;
            dat_s_q   <= dat_s_d;
            filt_q    <= filt_d;
            fcnt_q    <= fcnt_d;
            frame_q   <= frame_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tmo_q     <= tmo_d;
            pfx_q     <= pfx_d;
            last_q    <= last_d;
            data_q    <= data_d;
            cn_q      <= cn_d;
            err_q     <= err_d;
        end
    end

    assign data       = data_q;
    assign cifra_noua = cn_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Scoreboard bench for ps2_key_encoder: a table-driven key model predicts events,
// a monitor pops and compares on every strobe.
module tb_ps2_key_encoder;

    localparam int FL   = 8;
    localparam int TMO  = 1500;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [4:0] data;
    logic       cifra_noua, frame_err;

    ps2_key_encoder #(.FILTER_LEN(FL), .TIMEOUT(TMO), .TIMEOUT_W(11)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .data(data), .cifra_noua(cifra_noua), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {bit err; int d;} ev_t;
    ev_t exp_q[$];

    int n_total = 0, n_pass = 0;
    int map0[256], map1[256];
    bit m_ext, m_brk;
    int m_last, m_data;
    logic [7:0] mapped_codes[$];
    logic       prev_cn = 1'b0;

    logic [7:0] dig_main[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] dig_pad[10]  = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
    logic [7:0] ops[9]       = '{8'h5A, 8'h79, 8'h7B, 8'h7C, 8'h4A, 8'h2B, 8'h4D, 8'h2D, 8'h76};

    task automatic chk(input string nm, input int act, input int exp_v);
        n_total++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    endtask

    function automatic void push_ev(input bit err, input int d);
        ev_t e;
        e.err = err;
        e.d   = d;
        exp_q.push_back(e);
    endfunction

    // Key model: what a keyboard press/release means, from the scan-code tables.
    function automatic void model_byte(input logic [7:0] b);
        int code;
        code = m_ext ? map1[b] : map0[b];
        if (m_brk) begin
            if (code >= 0) begin
                push_ev(1'b0, 30);
                m_last = -1;
                m_data = 30;
            end
            m_brk = 0;
            m_ext = 0;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE0 && !m_ext) begin
            m_ext = 1;
        end else begin
            if (code >= 0 && code != m_last) begin
                push_ev(1'b0, code);
                m_last = code;
                m_data = code;
            end
            m_ext = 0;
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic frame(input logic [7:0] b, input bit par_flip = 0, input bit stop = 1);
        if (par_flip || !stop) begin
            push_ev(1'b1, 0);
            m_ext = 0;
            m_brk = 0;
        end else begin
            model_byte(b);
        end
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ par_flip);
        ps2_bit(stop);
        ps2_data = 1'b1;
        tick(HALF);
    endtask

    task automatic checkpoint(input string nm);
        tick(5);
        chk({nm, "_pending"}, exp_q.size(), 0);
        chk({nm, "_data_hold"}, int'(data), m_data);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (cifra_noua || frame_err) begin
                ev_t e;
                chk("strobe_exclusive", int'(cifra_noua && frame_err), 0);
                chk("strobe_spacing", int'(cifra_noua && prev_cn), 0);
                chk("event_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("event_kind_err", int'(frame_err), int'(e.err));
                    if (!e.err) chk("event_data", int'(data), e.d);
                end
            end
            prev_cn <= cifra_noua;
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            map0[i] = -1;
            map1[i] = -1;
        end
        for (int i = 0; i < 10; i++) begin
            map0[dig_main[i]] = i;
            map0[dig_pad[i]]  = i;
            mapped_codes.push_back(dig_main[i]);
            mapped_codes.push_back(dig_pad[i]);
        end
        for (int i = 0; i < 9; i++) begin
            map0[ops[i]] = 10 + i;
            mapped_codes.push_back(ops[i]);
        end
        map0[8'h5A] = 10;
        map1[8'h4A] = 14;
        map1[8'h5A] = 10;
        m_ext = 0; m_brk = 0; m_last = -1; m_data = 0;

        tick(5);
        chk("reset_data", int'(data), 0);
        chk("reset_cifra_noua", int'(cifra_noua), 0);
        chk("reset_frame_err", int'(frame_err), 0);
        rst = 1'b1;
        tick(10);

        frame(8'h16);
        checkpoint("single_16");
        frame(8'hF0); frame(8'h16);
        frame(8'h16); frame(8'h16); frame(8'h16);
        frame(8'hF0); frame(8'h16); frame(8'h16);
        checkpoint("typematic");
        frame(8'hE0); frame(8'h4A);
        frame(8'hE0); frame(8'hF0); frame(8'h4A);
        frame(8'hE0); frame(8'h75);
        checkpoint("extended");
        frame(8'h5A, 1);
        frame(8'h5A);
        checkpoint("parity_err");

        m_ext = 0; m_brk = 0;
        push_ev(1'b1, 0);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        tick(TMO + 10);
        checkpoint("timeout");
        frame(8'h76);
        checkpoint("after_timeout");

        frame(8'h45, 0, 0);
        checkpoint("stop_err");

        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        tick(FL - 2);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        tick(30);
        frame(8'h16);
        checkpoint("glitch");

        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
        rst = 1'b0;
        tick(3);
        chk("midreset_data", int'(data), 0);
        chk("midreset_cifra_noua", int'(cifra_noua), 0);
        chk("midreset_frame_err", int'(frame_err), 0);
        m_ext = 0; m_brk = 0; m_last = -1; m_data = 0;
        ps2_clk = 1'b1; ps2_data = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(30);
        frame(8'h16);
        checkpoint("after_midreset");

        for (int n = 0; n < 60; n++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 9);
            b = mapped_codes[$urandom_range(0, mapped_codes.size() - 1)];
            case (r)
                0:       frame(8'hE0);
                1:       frame(8'hF0);
                2:       frame(8'($urandom_range(0, 255)));
                3:       frame(b, 1);
                default: frame(b);
            endcase
            checkpoint("random");
        end

        chk("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
